// File: rtl/channel_send_sequencer.sv
// Per-channel transmit sequencer: clears the pre-FIFO on start, then plays
// frames from a circular SDRAM read window with blank gaps until stopped.
module channel_send_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int CLR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [LEN_W-1:0]  blank_len,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] rdaddr_begin,
    input  logic [ADDR_W-1:0] rdaddr_end,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              fifo_clr,
    output logic              frame_active,
    output logic              blank_active,
    output logic              busy,
    output logic [LEN_W-1:0]  frame_cnt,
    output logic              cfg_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_BLANK = 2'd3;

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              start_d;
    logic              stop_d;
    logic              stop_pend;
    logic              stop_pend_nx;
    logic [LEN_W-1:0]  flen_l;
    logic [LEN_W-1:0]  blen_l;
    logic [ADDR_W-1:0] begin_l;
    logic [ADDR_W-1:0] end_l;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  word_nx;
    logic [LEN_W-1:0]  blank_cnt;
    logic [LEN_W-1:0]  blank_nx;
    logic [CW-1:0]     clr_cnt;
    logic [CW-1:0]     clr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [LEN_W-1:0]  fcnt_nx;
    logic              err_nx;
    logic              latch;

    logic              start_rise;
    logic              stop_rise;
    logic              cfg_ok;
    logic              ack;
    logic              last_word;
    logic              stop_any;
    logic [ADDR_W-1:0] addr_inc;

    assign start_rise = start & ~start_d;
    assign stop_rise  = stop & ~stop_d;
    assign cfg_ok     = (frame_len != '0) && (rdaddr_begin <= rdaddr_end);
    // rd_req is high exactly while in FRAME, so it qualifies acks
    assign ack        = rd_req & rd_ack;
    assign last_word  = (word_cnt == flen_l - LEN_W'(1));
    assign stop_any   = stop_pend | stop_rise;
    assign addr_inc   = (rd_addr == end_l) ? begin_l : rd_addr + ADDR_W'(1);

    // Next-state and counter updates for the sequencer
    always_comb begin
        state_nx     = state;
        stop_pend_nx = stop_pend;
        addr_nx      = rd_addr;
        word_nx      = word_cnt;
        blank_nx     = blank_cnt;
        clr_nx       = clr_cnt;
        fcnt_nx      = frame_cnt;
        err_nx       = 1'b0;
        latch        = 1'b0;
        case (state)
            S_IDLE: begin
                stop_pend_nx = 1'b0;
                if (start_rise && !stop_rise) begin
                    if (cfg_ok) begin
                        latch    = 1'b1;
                        addr_nx  = rdaddr_begin;
                        fcnt_nx  = '0;
                        clr_nx   = '0;
                        state_nx = S_CLR;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_CLR: begin
                if (stop_rise) stop_pend_nx = 1'b1;
                word_nx = '0;
                if (clr_cnt == CLR_LAST) state_nx = S_FRAME;
                else clr_nx = clr_cnt + CW'(1);
            end
            S_FRAME: begin
                if (stop_rise) stop_pend_nx = 1'b1;
                if (ack) begin
                    addr_nx = addr_inc;
                    word_nx = word_cnt + LEN_W'(1);
                    if (last_word) begin
                        fcnt_nx = frame_cnt + LEN_W'(1);
                        word_nx = '0;
                        if (stop_any) begin
                            state_nx     = S_IDLE;
                            stop_pend_nx = 1'b0;
                        end else if (blen_l != '0) begin
                            state_nx = S_BLANK;
                            blank_nx = '0;
                        end
                    end
                end
            end
            S_BLANK: begin
                if (stop_any) begin
                    state_nx     = S_IDLE;
                    stop_pend_nx = 1'b0;
                end else if (blank_cnt == blen_l - LEN_W'(1)) begin
                    state_nx = S_FRAME;
                    word_nx  = '0;
                end else begin
                    blank_nx = blank_cnt + LEN_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, counters, latched config and edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            start_d   <= 1'b0;
            stop_d    <= 1'b0;
            stop_pend <= 1'b0;
            flen_l    <= '0;
            blen_l    <= '0;
            begin_l   <= '0;
            end_l     <= '0;
            word_cnt  <= '0;
            blank_cnt <= '0;
            clr_cnt   <= '0;
        end else begin
            state     <= state_nx;
            start_d   <= start;
            stop_d    <= stop;
            stop_pend <= stop_pend_nx;
            word_cnt  <= word_nx;
            blank_cnt <= blank_nx;
            clr_cnt   <= clr_nx;
            if (latch) begin
                flen_l  <= frame_len;
                blen_l  <= blank_len;
                begin_l <= rdaddr_begin;
                end_l   <= rdaddr_end;
            end
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            fifo_clr     <= 1'b0;
            frame_active <= 1'b0;
            blank_active <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
            cfg_err      <= 1'b0;
        end else begin
            rd_req       <= (state_nx == S_FRAME);
            rd_addr      <= addr_nx;
            fifo_clr     <= (state_nx == S_CLR);
            frame_active <= (state_nx == S_FRAME);
            blank_active <= (state_nx == S_BLANK);
            busy         <= (state_nx != S_IDLE);
            frame_cnt    <= fcnt_nx;
            cfg_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_channel_send_sequencer.sv
// Bench for channel_send_sequencer: directed and randomized runs checked
// against an address/frame/gap model derived from the playback rules.
module tb_channel_send_sequencer;

    localparam int ADDR_W     = 16;
    localparam int LEN_W      = 16;
    localparam int CLR_CYCLES = 4;
    localparam int BUDGET     = 5000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [LEN_W-1:0]  frame_len = '0;
    logic [LEN_W-1:0]  blank_len = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] rdaddr_begin = '0;
    logic [ADDR_W-1:0] rdaddr_end = '0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack = 1'b0;
    logic              fifo_clr;
    logic              frame_active;
    logic              blank_active;
    logic              busy;
    logic [LEN_W-1:0]  frame_cnt;
    logic              cfg_err;

    int errors = 0;
    int checks = 0;

    channel_send_sequencer #(
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_len(frame_len),
        .blank_len(blank_len),
        .start(start),
        .stop(stop),
        .rdaddr_begin(rdaddr_begin),
        .rdaddr_end(rdaddr_end),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_ack(rd_ack),
        .fifo_clr(fifo_clr),
        .frame_active(frame_active),
        .blank_active(blank_active),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int fr);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, rd_req, 0);
        chk({tag, "_fact"}, frame_active, 0);
        chk({tag, "_bact"}, blank_active, 0);
        chk({tag, "_fcnt"}, frame_cnt, fr);
    endtask

    // Play nfr frames, stopping at word soff of the last one.
    // mode: 0 ack every cycle, 1 ack every 3rd cycle, 2 random ack.
    task automatic run(input logic [15:0] b, input int span, input int fl,
                       input int bl, input int nfr, input int soff,
                       input int mode);
        int k, fr, gap, acnt, cyc, n, stop_at;
        bit fin, stop_sent, start_sent, exp_req, a;
        logic [15:0] exp_addr;
        frame_len    = fl[15:0];
        blank_len    = bl[15:0];
        rdaddr_begin = b;
        rdaddr_end   = b + 16'(span - 1);
        start = 1'b1;
        step();
        start = 1'b0;
        frame_len    = 16'($urandom);
        blank_len    = 16'($urandom);
        rdaddr_begin = 16'($urandom);
        rdaddr_end   = 16'($urandom);
        chk("clr_on", fifo_clr, 1);
        chk("clr_busy", busy, 1);
        chk("clr_req", rd_req, 0);
        n = 1;
        while (fifo_clr === 1'b1 && n < 64) begin
            step();
            if (fifo_clr === 1'b1) n++;
        end
        chk("clr_len", n, CLR_CYCLES);
        k = 0; fr = 0; gap = 0; acnt = 0; cyc = 0;
        fin = 0; stop_sent = 0; start_sent = 0;
        stop_at = (nfr - 1) * fl + soff;
        while (!fin && cyc < BUDGET) begin
            exp_req = (gap == 0);
            chk("rd_req", rd_req, exp_req);
            chk("blank_act", blank_active, !exp_req);
            chk("frame_cnt", frame_cnt, fr);
            chk("busy", busy, 1);
            chk("no_cfg_err", cfg_err, 0);
            rd_ack = 1'b0;
            stop = 1'b0;
            start = 1'b0;
            if (exp_req) begin
                exp_addr = b + 16'(k % span);
                chk("rd_addr", rd_addr, exp_addr);
                if (k == stop_at && !stop_sent) begin
                    stop = 1'b1;
                    stop_sent = 1;
                end
                if (k == 1 && !start_sent) begin
                    start = 1'b1;
                    start_sent = 1;
                end
                case (mode)
                    0: a = 1;
                    1: a = (acnt % 3 == 2);
                    default: a = 1'($urandom_range(0, 1));
                endcase
                acnt++;
                rd_ack = a;
                if (a) begin
                    k++;
                    if (k % fl == 0) begin
                        fr++;
                        if (fr == nfr) fin = 1;
                        else gap = bl;
                    end
                end
            end else begin
                rd_ack = 1'($urandom_range(0, 1));
                gap--;
            end
            step();
            cyc++;
        end
        rd_ack = 1'b0;
        stop = 1'b0;
        start = 1'b0;
        chk("timeout", (cyc < BUDGET) ? 1 : 0, 1);
        chk_idle("end", nfr);
        step();
        chk_idle("end2", nfr);
    endtask

    initial begin
        int i;
        #12;
        chk_idle("rst", 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_clr", fifo_clr, 0);
        chk("rst_err", cfg_err, 0);
        reset_n = 1'b1;
        step();

        run(16'h0010, 16, 4, 3, 2, 1, 0);
        run(16'h0020, 3, 5, 0, 3, 0, 0);
        run(16'h0040, 8, 8, 2, 1, 1, 0);
        run(16'h0100, 5, 6, 2, 2, 3, 1);

        // stop while in BLANK
        frame_len = 16'd2; blank_len = 16'd6;
        rdaddr_begin = 16'h0300; rdaddr_end = 16'h0303;
        start = 1'b1; step(); start = 1'b0;
        rd_ack = 1'b1;
        i = 0;
        while (blank_active !== 1'b1 && i < 100) begin
            step();
            i++;
        end
        rd_ack = 1'b0;
        chk("blank_seen", blank_active, 1);
        step();
        stop = 1'b1; step(); stop = 1'b0;
        chk_idle("blank_stop", 1);

        // bad configs
        frame_len = 16'd0; blank_len = 16'd1;
        rdaddr_begin = 16'h0000; rdaddr_end = 16'h0005;
        start = 1'b1; step(); start = 1'b0;
        chk("err_len0", cfg_err, 1);
        chk("err_len0_busy", busy, 0);
        step();
        chk("err_len0_pulse", cfg_err, 0);
        chk("err_len0_busy2", busy, 0);
        frame_len = 16'd4;
        rdaddr_begin = 16'h0030; rdaddr_end = 16'h002F;
        start = 1'b1; step(); start = 1'b0;
        chk("err_win", cfg_err, 1);
        chk("err_win_busy", busy, 0);
        step();
        chk("err_win_pulse", cfg_err, 0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        chk("ss_bad_err", cfg_err, 0);
        chk("ss_bad_busy", busy, 0);
        rdaddr_end = 16'h0040;
        step();
        start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        chk("ss_good_err", cfg_err, 0);
        chk("ss_good_busy", busy, 0);
        step();
        chk("ss_good_busy2", busy, 0);
        chk("ss_good_clr", fifo_clr, 0);

        // reset mid-frame
        frame_len = 16'd10; blank_len = 16'd1;
        rdaddr_begin = 16'h0050; rdaddr_end = 16'h0053;
        start = 1'b1; step(); start = 1'b0;
        i = 0;
        while (rd_req !== 1'b1 && i < 20) begin
            step();
            i++;
        end
        chk("mid_req", rd_req, 1);
        rd_ack = 1'b1;
        step(); step(); step();
        #2 reset_n = 1'b0;
        #1;
        chk_idle("mid_rst", 0);
        chk("mid_rst_addr", rd_addr, 0);
        rd_ack = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        run(16'h0200, 7, 3, 1, 2, 2, 2);

        for (int r = 0; r < 8; r++) begin
            int span, fl, bl, nfr, soff, mode;
            logic [15:0] b;
            b    = 16'($urandom_range(0, 16'hFF00));
            span = $urandom_range(1, 8);
            fl   = $urandom_range(1, 10);
            bl   = $urandom_range(0, 4);
            nfr  = $urandom_range(1, 3);
            soff = $urandom_range(0, fl - 1);
            mode = $urandom_range(0, 2);
            run(b, span, fl, bl, nfr, soff, mode);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
